// File: rtl/dif_tf_const_bank.sv
// dif_tf_const_bank
// Bank of twiddle constants for a decimation-in-frequency FFT. The table holds
// NUM_STAGES x NUM_CH constants. A read returns every channel of one stage at
// once, one cycle later. The whole table can be reloaded through a beat stream.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst_n          asynchronous active-low reset, restores INIT_TABLE
//   CEN            active-low read enable
//   stage_counter  stage to read
//   load_start     pulse, starts (or restarts) a bulk reload
//   load_valid     load beat valid
//   load_data      load beat, written in stage-major, channel-minor order
//   load_ready     high while a reload is in progress
//   load_done      one-cycle pulse after the final beat is written
//   Q              channel c of the read stage at [c*P_WIDTH +: P_WIDTH]
//   q_valid        Q was updated by a valid read this cycle
//   stage_err      one-cycle pulse after a read of a stage that does not exist
module dif_tf_const_bank #(
    parameter int P_WIDTH    = 64,
    parameter int SC_WIDTH   = 3,
    parameter int NUM_STAGES = 4,
    parameter int NUM_CH     = 4,
    // Entry (stage*NUM_CH + ch) sits at bits [(stage*NUM_CH + ch)*P_WIDTH +: P_WIDTH].
    parameter logic [NUM_STAGES*NUM_CH*P_WIDTH-1:0] INIT_TABLE = {
        {((NUM_STAGES*NUM_CH-4)*P_WIDTH){1'b0}},
        64'h75c91fcd00f90ea6,
        64'h4a3f9ccc62d9a86a,
        64'h252502e45f699196,
        64'h381d997f2d35d682
    }
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        CEN,
    input  logic [SC_WIDTH-1:0]         stage_counter,
    input  logic                        load_start,
    input  logic                        load_valid,
    input  logic [P_WIDTH-1:0]          load_data,
    output logic                        load_ready,
    output logic                        load_done,
    output logic [NUM_CH*P_WIDTH-1:0]   Q,
    output logic                        q_valid,
    output logic                        stage_err
);

    localparam int N_ENTRIES = NUM_STAGES * NUM_CH;
    localparam int PTR_W     = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_ENTRIES - 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t                 state;
    logic [PTR_W-1:0]       wr_ptr;
    logic [P_WIDTH-1:0]     table_q [N_ENTRIES];

    logic                   rd_in_range;
    logic [NUM_CH*P_WIDTH-1:0] rd_data;

    // Gather every channel of the requested stage. Stage numbers that do not
    // exist never reach the table index, they are reported as stage_err.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = '0;
        rd_data     = '0;
        rd_in_range = (32'(stage_counter) < 32'(NUM_STAGES));
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_in_range) begin
                idx = PTR_W'(32'(stage_counter) * 32'(NUM_CH) + 32'(c));
                rd_data[c*P_WIDTH +: P_WIDTH] = table_q[idx];
            end
        end
    end

    assign load_ready = (state == S_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            wr_ptr    <= '0;
            Q         <= '0;
            q_valid   <= 1'b0;
            load_done <= 1'b0;
            stage_err <= 1'b0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                table_q[PTR_W'(i)] <= INIT_TABLE[i*P_WIDTH +: P_WIDTH];
            end
        end else begin
            q_valid   <= 1'b0;
            load_done <= 1'b0;
            stage_err <= 1'b0;
            case (state)
                S_RUN: begin
                    // A reload request wins over a read in the same cycle.
                    if (load_start) begin
                        state  <= S_LOAD;
                        wr_ptr <= '0;
                    end else if (!CEN) begin
                        if (rd_in_range) begin
                            Q       <= rd_data;
                            q_valid <= 1'b1;
                        end else begin
                            stage_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    // Restart drops the coincident beat; entries already
                    // written keep their new values.
                    if (load_start) begin
                        wr_ptr <= '0;
                    end else if (load_valid) begin
                        table_q[wr_ptr] <= load_data;
                        if (wr_ptr == LAST_PTR) begin
                            wr_ptr    <= '0;
                            state     <= S_RUN;
                            load_done <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_dif_tf_const_bank.sv
// tb_dif_tf_const_bank
// Scoreboard bench for dif_tf_const_bank with default parameters. Each driven
// cycle is fed to a behavioural model whose expected outputs are queued and
// compared one cycle later against the DUT.
module tb_dif_tf_const_bank;

    localparam int PW  = 64;
    localparam int NCH = 4;
    localparam int NST = 4;
    localparam int NE  = NST * NCH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              CEN;
    logic [2:0]        stage_counter;
    logic              load_start;
    logic              load_valid;
    logic [PW-1:0]     load_data;
    logic              load_ready;
    logic              load_done;
    logic [NCH*PW-1:0] Q;
    logic              q_valid;
    logic              stage_err;

    dif_tf_const_bank dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .CEN           (CEN),
        .stage_counter (stage_counter),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .load_done     (load_done),
        .Q             (Q),
        .q_valid       (q_valid),
        .stage_err     (stage_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH*PW-1:0] q;
        logic              qv;
        logic              se;
        logic              ld;
        logic              lr;
    } exp_t;

    exp_t          exp_q [$];
    int            checks = 0;
    int            errors = 0;
    int            done_seen = 0;

    logic [PW-1:0] m_tab [NE];
    logic [NCH*PW-1:0] m_q;
    logic          m_load;
    int            m_ptr;

    task automatic chk(input string tag, input logic [NCH*PW-1:0] got,
                       input logic [NCH*PW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) m_tab[i] = '0;
        m_tab[0] = 64'h381d997f2d35d682;
        m_tab[1] = 64'h252502e45f699196;
        m_tab[2] = 64'h4a3f9ccc62d9a86a;
        m_tab[3] = 64'h75c91fcd00f90ea6;
        m_q    = '0;
        m_load = 1'b0;
        m_ptr  = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic cen, input int sc, input logic ls,
                              input logic lv, input logic [PW-1:0] d);
        exp_t e;
        e = '0;
        if (!m_load) begin
            if (ls) begin
                m_load = 1'b1;
                m_ptr  = 0;
            end else if (!cen) begin
                if (sc < NST) begin
                    for (int c = 0; c < NCH; c++) m_q[c*PW +: PW] = m_tab[sc*NCH + c];
                    e.qv = 1'b1;
                end else begin
                    e.se = 1'b1;
                end
            end
        end else begin
            if (ls) begin
                m_ptr = 0;
            end else if (lv) begin
                m_tab[m_ptr] = d;
                if (m_ptr == NE - 1) begin
                    m_ptr  = 0;
                    m_load = 1'b0;
                    e.ld   = 1'b1;
                end else begin
                    m_ptr++;
                end
            end
        end
        e.q  = m_q;
        e.lr = m_load;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, advance the model, then compare after the edge.
    task automatic cyc(input logic cen, input int sc, input logic ls,
                       input logic lv, input logic [PW-1:0] d);
        exp_t e;
        CEN           = cen;
        stage_counter = 3'(sc);
        load_start    = ls;
        load_valid    = lv;
        load_data     = d;
        model_step(cen, sc, ls, lv, d);
        @(posedge clk);
        #1;
        if (load_done === 1'b1) done_seen++;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("Q", Q, e.q);
            chk("q_valid", {255'b0, q_valid}, {255'b0, e.qv});
            chk("stage_err", {255'b0, stage_err}, {255'b0, e.se});
            chk("load_done", {255'b0, load_done}, {255'b0, e.ld});
            chk("load_ready", {255'b0, load_ready}, {255'b0, e.lr});
        end
    endtask

    task automatic idle();
        cyc(1'b1, 0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_in_reset(input string tag);
        chk({tag, "_Q"}, Q, '0);
        chk({tag, "_flags"}, {251'b0, q_valid, stage_err, load_done, load_ready, 1'b0}, '0);
    endtask

    initial begin
        CEN = 1'b1; stage_counter = '0; load_start = 1'b0;
        load_valid = 1'b0; load_data = '0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_in_reset("rst0");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Default table, stage 0 read on the first edge after reset
        cyc(1'b0, 0, 1'b0, 1'b0, '0);
        chk("init_ch0", {192'b0, Q[0 +: 64]},   {192'b0, 64'h381d997f2d35d682});
        chk("init_ch3", {192'b0, Q[192 +: 64]}, {192'b0, 64'h75c91fcd00f90ea6});
        cyc(1'b0, 1, 1'b0, 1'b0, '0);
        cyc(1'b0, 2, 1'b0, 1'b0, '0);
        chk("stage2_zero", Q, '0);
        cyc(1'b0, 0, 1'b0, 1'b0, '0);
        cyc(1'b0, 5, 1'b0, 1'b0, '0);
        cyc(1'b0, 7, 1'b0, 1'b1, 64'h55);
        cyc(1'b1, 3, 1'b0, 1'b1, 64'h66);
        idle();

        // Full reload 0x1..0x10 with gaps, CEN low during the load
        done_seen = 0;
        cyc(1'b0, 1, 1'b1, 1'b0, '0);
        for (int i = 1; i <= NE; i++) begin
            if (i % 3 == 0) cyc(1'b0, 0, 1'b0, 1'b0, 64'hbad);
            cyc(i[0], 0, 1'b0, 1'b1, PW'(i));
        end
        cyc(1'b0, 3, 1'b0, 1'b0, '0);
        chk("load1_done_once", 256'(done_seen), 256'd1);
        chk("load1_stage3", Q, {64'h10, 64'hF, 64'hE, 64'hD});
        cyc(1'b1, 0, 1'b0, 1'b0, '0);
        cyc(1'b0, 0, 1'b0, 1'b0, '0);

        // Restart after beat 5; the restart-cycle beat is discarded
        done_seen = 0;
        cyc(1'b1, 0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 0, 1'b0, 1'b1, 64'hA0 + PW'(i));
        cyc(1'b1, 0, 1'b1, 1'b1, 64'hdead);
        for (int i = 0; i < NE; i++) begin
            if (i == 4) idle();
            cyc(1'b1, 0, 1'b0, 1'b1, 64'h100 + PW'(i));
        end
        cyc(1'b0, 0, 1'b0, 1'b0, '0);
        chk("load2_done_once", 256'(done_seen), 256'd1);
        chk("load2_s0c0", {192'b0, Q[0 +: 64]}, {192'b0, 64'h100});
        cyc(1'b0, 3, 1'b0, 1'b0, '0);

        // Read and reload request in the same cycle: reload wins
        cyc(1'b0, 1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 0, 1'b0, 1'b1, 64'hC0 + PW'(i));

        // Reset mid-load aborts and restores the initial table
        rst_n = 1'b0;
        model_reset();
        #2;
        check_in_reset("rst_mid");
        @(posedge clk); #1;
        check_in_reset("rst_hold");
        rst_n = 1'b1;
        cyc(1'b0, 0, 1'b0, 1'b0, '0);
        chk("post_rst_ch1", {192'b0, Q[64 +: 64]}, {192'b0, 64'h252502e45f699196});
        cyc(1'b0, 1, 1'b0, 1'b0, '0);
        cyc(1'b1, 2, 1'b0, 1'b0, '0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dif_tf_const_bank.md
DIF_TF_CONST_BANK -- requirements
Module: dif_tf_const_bank

Interface
REQ-001 Parameter P_WIDTH, default 64, width of one twiddle constant.
REQ-002 Parameter SC_WIDTH, default 3, width of stage_counter.
REQ-003 Parameter NUM_STAGES, default 4, stages holding constants (1..2^SC_WIDTH).
REQ-004 Parameter NUM_CH, default 4, constant outputs per stage.
REQ-005 Parameter INIT_TABLE, default stage0 ch0..3 = 64'h381d997f2d35d682, 64'h252502e45f699196, 64'h4a3f9ccc62d9a86a, 64'h75c91fcd00f90ea6, all other entries 0; flattened NUM_STAGES*NUM_CH*P_WIDTH, entry index = stage*NUM_CH+ch.
REQ-006 clk  input  1  clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 CEN  input  1  active-low read enable.
REQ-009 stage_counter  input  SC_WIDTH  stage to read.
REQ-010 load_start  input  1  pulse; begins bulk reload of table.
REQ-011 load_valid  input  1  load data beat valid.
REQ-012 load_data  input  P_WIDTH  load data beat.
REQ-013 load_ready  output  1  high while in LOAD state.
REQ-014 load_done  output  1  one-cycle pulse when last entry written.
REQ-015 Q  output  NUM_CH*P_WIDTH  channel c at bits [c*P_WIDTH +: P_WIDTH].
REQ-016 q_valid  output  1  Q updated this cycle from a valid read.
REQ-017 stage_err  output  1  one-cycle pulse on read with stage_counter >= NUM_STAGES.

Function
REQ-018 Storage: NUM_STAGES*NUM_CH registers of P_WIDTH bits.
REQ-019 FSM states RUN and LOAD; RUN -> LOAD on load_start; LOAD -> RUN on the cycle the final beat is accepted.
REQ-020 RUN read: CEN=0 and stage_counter < NUM_STAGES -> next cycle Q = all NUM_CH entries of that stage, q_valid=1 (latency 1).
REQ-021 RUN with CEN=1 -> Q holds, q_valid=0.
REQ-022 Out-of-range read (CEN=0, stage_counter >= NUM_STAGES) -> Q holds, q_valid=0, stage_err=1 next cycle.
REQ-023 LOAD entry clears write pointer to 0; load_ready=1 throughout LOAD.
REQ-024 LOAD beat: load_valid=1 writes load_data to entry[pointer], pointer+1; order stage-major, channel-minor.
REQ-025 Beat at pointer NUM_STAGES*NUM_CH-1 -> write, pointer to 0, state RUN, load_done=1 next cycle.
REQ-026 In LOAD, reads ignored: Q holds, q_valid=0, stage_err=0, regardless of CEN.
REQ-027 load_start while in LOAD restarts: pointer to 0, the same-cycle load_valid beat is discarded, entries already written keep new values.
REQ-028 load_valid in RUN is ignored; load_start takes priority over a read in the same cycle (read dropped).
REQ-029 A read in the cycle following load_done returns newly loaded values.
REQ-030 Pointer width = clog2(NUM_STAGES*NUM_CH), minimum 1; no wrap past last entry.

Reset
REQ-031 rst_n low -> immediately: table = INIT_TABLE, Q=0, q_valid=0, load_ready=0, load_done=0, stage_err=0, pointer=0, state RUN.
REQ-032 Reset mid-LOAD aborts the load; partially loaded entries revert to INIT_TABLE.
REQ-033 First read is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-034 Reset, CEN=0, stage_counter=0 -> next cycle Q ch0..3 = 381d997f2d35d682, 252502e45f699196, 4a3f9ccc62d9a86a, 75c91fcd00f90ea6, q_valid=1.
REQ-035 Read stage 2 with defaults -> Q=0, q_valid=1; stage_counter=5 -> stage_err=1, q_valid=0, Q unchanged.
REQ-036 load_start, then 16 beats 0x1..0x10 with load_valid gaps -> load_done once after beat 16; read stage 3 -> Q ch0..3 = 0xD, 0xE, 0xF, 0x10.
REQ-037 load_start after beat 5 of 16, then 16 beats 0x100..0x10F -> stage 0 ch0 = 0x100, load_done exactly once.
REQ-038 rst_n pulsed low after beat 7 -> stage 0 reads INIT values, load_ready=0, Q=0 during reset.
REQ-039 CEN=0 during LOAD -> q_valid stays 0; CEN=1 in RUN -> Q holds last value.
